// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator: operation encoding and
// signed saturation limits.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Returns 0111..1 in the low w bits; callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned w);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i + 1 < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Returns 1000..0 in the low w bits.
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned w);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i + 1 == w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational arithmetic core: add/sub/accumulate/load with carry, signed
// overflow detection and optional saturation.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_dataa,
  input  logic [WIDTH-1:0] i_datab,
  input  logic [WIDTH-1:0] i_acc,
  input  op_e              i_op,
  input  logic             i_sat_mode,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_raw;

  always_comb begin
    w_opa   = i_dataa;
    w_opb   = i_datab;
    w_sum   = '0;
    w_raw   = i_dataa;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    case (i_op)
      OP_ADD, OP_ACC: begin
        w_opa   = (i_op == OP_ACC) ? i_acc   : i_dataa;
        w_opb   = (i_op == OP_ACC) ? i_dataa : i_datab;
        w_sum   = {1'b0, w_opa} + {1'b0, w_opb};
        w_raw   = w_sum[MSB:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (w_opa[MSB] == w_opb[MSB]) && (w_sum[MSB] != w_opa[MSB]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the unsigned borrow.
        w_sum   = {1'b0, i_dataa} - {1'b0, i_datab};
        w_raw   = w_sum[MSB:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (i_dataa[MSB] != i_datab[MSB]) && (w_sum[MSB] != i_dataa[MSB]);
      end
      OP_LOAD: begin
        w_raw = i_dataa;
      end
    endcase
    // Overflow direction follows the sign of the first operand.
    o_result = (i_sat_mode && o_ovf) ? (w_opa[MSB] ? SMIN : SMAX) : w_raw;
  end

endmodule

// File: rtl/addsub_acc.sv
// Add/subtract accumulator with a single valid/ready output stage, internal
// accumulator, programmable saturation and a sticky overflow flag.
module addsub_acc
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          SAT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             sat_wr,
  input  logic             sat_val,
  input  logic             sticky_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             ovf_sticky
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_sticky;
  logic [WIDTH-1:0] r_acc;
  logic             r_sat_mode;

  op_e              w_op;
  logic             w_accept;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_ovf;

  assign w_op     = op_e'(op);
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_dataa   (dataa),
    .i_datab   (datab),
    .i_acc     (r_acc),
    .i_op      (w_op),
    .i_sat_mode(r_sat_mode),
    .o_result  (w_result),
    .o_carry   (w_carry),
    .o_ovf     (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_sticky    <= 1'b0;
      r_acc       <= '0;
      r_sat_mode  <= SAT_DEFAULT;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_result    <= w_result;
        r_carry     <= w_carry;
        r_ovf       <= w_ovf;
        if (w_op == OP_ACC || w_op == OP_LOAD) r_acc <= w_result;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A new overflow takes priority over a simultaneous clear.
      if (w_accept && w_ovf) r_sticky <= 1'b1;
      else if (sticky_clr)   r_sticky <= 1'b0;
      if (sat_wr) r_sat_mode <= sat_val;
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign carry      = r_carry;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_addsub_acc.sv
// Scoreboard bench for addsub_acc (WIDTH=8): directed corner cases followed by
// randomized traffic against an integer-arithmetic reference model.
module tb_addsub_acc;

  typedef struct {
    logic [7:0] result;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] dataa;
  logic [7:0] datab;
  logic       sat_wr;
  logic       sat_val;
  logic       sticky_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       ovf;
  logic       ovf_sticky;

  addsub_acc #(
    .WIDTH      (8),
    .SAT_DEFAULT(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dataa     (dataa),
    .datab     (datab),
    .sat_wr    (sat_wr),
    .sat_val   (sat_val),
    .sticky_clr(sticky_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Reference state: "cur" is what the DUT shows now, "nxt" after the coming edge.
  bit   cur_ov, nxt_ov, cur_sticky, nxt_sticky, m_sat;
  int   m_acc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int to_signed8(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  function automatic exp_t ref_op(input logic [1:0] o, input int ua, input int ub,
                                  input int uacc, input bit sat);
    exp_t e;
    int   s;
    int   r;
    bit   c;
    c = 1'b0;
    case (o)
      2'd0:    begin s = to_signed8(ua) + to_signed8(ub);   c = (ua + ub) > 255;   end
      2'd1:    begin s = to_signed8(ua) - to_signed8(ub);   c = ua < ub;           end
      2'd2:    begin s = to_signed8(uacc) + to_signed8(ua); c = (uacc + ua) > 255; end
      default: begin s = to_signed8(ua); end
    endcase
    e.ovf = (s > 127) || (s < -128);
    if (sat && e.ovf) r = (s > 127) ? 127 : -128;
    else              r = s;
    e.result = 8'(r & 255);
    e.carry  = c;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] b, input bit sw, input bit sv,
                       input bit clr, input bit ordy);
    exp_t e;
    bit   acc_ok;
    @(posedge clk);
    cur_ov     = nxt_ov;
    cur_sticky = nxt_sticky;
    #2;
    in_valid = v; op = o; dataa = a; datab = b;
    sat_wr = sw; sat_val = sv; sticky_clr = clr; out_ready = ordy;
    #1;
    check("in_ready",   in_ready,   (!cur_ov) || ordy);
    check("out_valid",  out_valid,  cur_ov);
    check("ovf_sticky", ovf_sticky, cur_sticky);
    acc_ok = v && (!cur_ov || ordy);
    if (acc_ok) begin
      e = ref_op(o, int'(a), int'(b), m_acc, m_sat);
      sb_q.push_back(e);
      if (o == 2'd2 || o == 2'd3) m_acc = int'(e.result);
      nxt_ov = 1'b1;
    end else if (ordy) begin
      nxt_ov = 1'b0;
    end
    if (acc_ok && e.ovf) nxt_sticky = 1'b1;
    else if (clr)        nxt_sticky = 1'b0;
    if (sw) m_sat = sv;
  endtask

  // Monitor: compares the held output every cycle, retires it when consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output act=%0h exp=none", result);
        end else begin
          e = sb_q[0];
          check("result", result, e.result);
          check("carry",  carry,  e.carry);
          check("ovf",    ovf,    e.ovf);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; dataa = '0; datab = '0;
    sat_wr = 1'b0; sat_val = 1'b0; sticky_clr = 1'b0; out_ready = 1'b0;
    cur_ov = 0; nxt_ov = 0; cur_sticky = 0; nxt_sticky = 0; m_sat = 0; m_acc = 0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result",    result,    8'h00);
    check("rst_sticky",    ovf_sticky, 1'b0);
    #20 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1'b1);

    // Overflow, saturation mode switch (old mode applies on the write edge)
    drive(1, 2'd0, 8'h7F, 8'h01, 0, 0, 0, 1);
    drive(1, 2'd0, 8'h7F, 8'h01, 1, 1, 0, 1);
    drive(1, 2'd0, 8'h7F, 8'h01, 0, 0, 0, 1);
    drive(1, 2'd1, 8'h00, 8'h01, 0, 0, 0, 1);
    drive(1, 2'd1, 8'h80, 8'h01, 0, 0, 0, 1);
    drive(1, 2'd0, 8'h7F, 8'h01, 0, 0, 1, 1);
    drive(0, 2'd0, 8'h00, 8'h00, 1, 0, 1, 1);
    drive(0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);

    // Back-to-back accumulate chain
    drive(1, 2'd3, 8'h10, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 2'd2, 8'h05, 8'hAA, 0, 0, 0, 1);

    // Backpressure: offered ACC must be ignored while the output is held
    drive(1, 2'd3, 8'h20, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 2'd2, 8'h01, 8'h00, 0, 0, 0, 0);
    drive(1, 2'd2, 8'h01, 8'h00, 0, 0, 0, 1);
    drive(0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);

    // Asynchronous reset with a held result and acc=0x3C
    drive(1, 2'd0, 8'h7F, 8'h7F, 0, 0, 0, 1);
    drive(1, 2'd3, 8'h3C, 8'h00, 0, 0, 0, 1);
    drive(0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid,  1'b0);
    check("arst_result",    result,     8'h00);
    check("arst_carry",     carry,      1'b0);
    check("arst_ovf",       ovf,        1'b0);
    check("arst_sticky",    ovf_sticky, 1'b0);
    check("arst_acc",       dut.r_acc,  8'h00);
    sb_q.delete();
    cur_ov = 0; nxt_ov = 0; cur_sticky = 0; nxt_sticky = 0; m_sat = 0; m_acc = 0;
    in_valid = 1'b1; op = 2'd3; dataa = 8'hFF; out_ready = 1'b1;
    @(posedge clk);
    #1 check("rst_no_accept", out_valid, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1'b1);
    drive(1, 2'd2, 8'h00, 8'h00, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom),
            $urandom_range(0, 19) == 0, 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 3; i++) drive(0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addsub_acc.md
ADDSUB_ACC -- requirements
Module: addsub_acc

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width (>=2).
REQ-002 SHALL provide parameter SAT_DEFAULT, default 0, saturation-mode value loaded at reset.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-004 Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- op  in  2  00 ADD, 01 SUB, 10 ACC (acc+dataa), 11 LOAD (acc=dataa)
- dataa  in  WIDTH  operand A, two's complement
- datab  in  WIDTH  operand B, ignored for ACC/LOAD
- sat_wr  in  1  write sat_mode from sat_val
- sat_val  in  1  new saturation mode
- sticky_clr  in  1  clear sticky overflow flag
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- result  out  WIDTH  arithmetic result
- carry  out  1  unsigned carry-out (ADD/ACC) or borrow (SUB)
- ovf  out  1  signed overflow of this operation, before saturation
- ovf_sticky  out  1  OR of all ovf since reset/clear

Function
REQ-005 ADD: dataa+datab; SUB: dataa-datab; ACC: acc+dataa; LOAD: dataa; all computed at WIDTH+1 bits.
REQ-006 carry SHALL be bit WIDTH of the unsigned sum for ADD/ACC, 1 when dataa<datab unsigned for SUB, 0 for LOAD.
REQ-007 ovf SHALL be 1 when operands share sign and result sign differs (ADD/ACC), or operand signs differ and result sign differs from dataa (SUB); 0 for LOAD.
REQ-008 With sat_mode=1 and ovf=1, result SHALL clamp to signed max (0111..1) on positive overflow and signed min (1000..0) on negative; otherwise wrap modulo 2^WIDTH.
REQ-009 Latency: an operation accepted at edge N SHALL present result/carry/ovf with out_valid=1 after edge N.
REQ-010 in_ready SHALL equal !out_valid | out_ready (combinational, single output stage, full throughput).
REQ-011 Output register SHALL hold result, flags, and out_valid stable while out_valid & !out_ready.
REQ-012 out_valid SHALL clear on an edge where out_ready=1 and no new operation is accepted.
REQ-013 Internal accumulator acc (WIDTH) SHALL update only on accepted ACC/LOAD, to the post-saturation result; ADD/SUB SHALL leave acc unchanged.
REQ-014 Back-to-back ACC operations SHALL each use acc as updated by the preceding accepted ACC/LOAD.
REQ-015 sat_wr SHALL update sat_mode at the edge; an operation accepted at the same edge SHALL use the old sat_mode.
REQ-016 ovf_sticky SHALL set on any accepted operation with ovf=1; simultaneous sticky_clr and set SHALL leave ovf_sticky=1 (set wins).
REQ-017 Operations offered while in_ready=0 SHALL have no effect on acc, flags, or output.

Reset
REQ-018 On rst_n=0, immediately and asynchronously: out_valid=0, result=0, carry=0, ovf=0, ovf_sticky=0, acc=0, sat_mode=SAT_DEFAULT.
REQ-019 Reset mid-transaction SHALL discard the held result; no operation SHALL be accepted while rst_n=0; after release in_ready=1.

Structure
REQ-020 A shared package addsub_pkg SHALL hold the op_e enumeration (OP_ADD, OP_SUB, OP_ACC, OP_LOAD) and the saturation-limit helper constants.
REQ-021 The combinational core SHALL be one sub-module addsub_core (operands, op, sat_mode -> result, carry, ovf); the handshake, acc, and sticky registers SHALL live in addsub_acc.

Verification (WIDTH=8)
REQ-022 ADD 0x7F+0x01, sat off -> result 0x80, ovf=1, carry=0, ovf_sticky=1 after accept; sat on -> result 0x7F.
REQ-023 SUB 0x00-0x01 -> result 0xFF, carry(borrow)=1, ovf=0; SUB 0x80-0x01 sat on -> 0x80, ovf=1.
REQ-024 LOAD 0x10, then ACC 0x05 x3 back-to-back with out_ready=1 -> results 0x10,0x15,0x1A,0x1F on consecutive cycles, in_ready constantly 1.
REQ-025 out_ready=0 for 4 cycles with result held -> in_ready=0, result stable, offered ACC ignored, acc unchanged; on out_ready=1 the next op is accepted the same edge.
REQ-026 Assert rst_n=0 mid-cycle with out_valid=1 and acc=0x3C -> out_valid, acc, flags 0 without a clock edge; sticky_clr together with an overflowing op -> ovf_sticky stays 1.
